wb_picorv32_master: RTL and testbench
=====================================

Name: wb_picorv32_master

Overview:
Bridge from the picorv32 native memory interface to a pipelined Wishbone master port. It is the initiator end of the bus our peripherals (LEDs, UART, etc.) respond on. It turns each mem_valid request into exactly one Wishbone single cycle, waits for ack, err or timeout, and returns one mem_ready pulse. Only one transaction is outstanding at a time.

Parameters:
- TIMEOUT_CYCLES, 255: cycles from stb assertion to forced abort; 0 disables the timeout.
- ERR_RDATA, 32'hDEAD_BEEF: read data returned on err or timeout.

Ports:
- i_clk  in  1  system clock
- i_reset_n  in  1  reset; asynchronous, active-low
- i_mem_valid  in  1  CPU request
- i_mem_instr  in  1  instruction fetch flag; ignored beyond the read path
- i_mem_addr  in  32  byte address
- i_mem_wdata  in  32  write data
- i_mem_wstrb  in  4  byte strobes; 0 means read
- o_mem_ready  out  1  one-cycle completion pulse
- o_mem_rdata  out  32  read data, valid while o_mem_ready=1
- o_wb_addr  out  32  Wishbone address
- o_wb_data  out  32  Wishbone write data
- o_wb_sel  out  4  byte selects
- o_wb_we  out  1  write enable
- o_wb_cyc  out  1  cycle
- o_wb_stb  out  1  strobe
- i_wb_ack  in  1  slave ack
- i_wb_data  in  32  slave read data
- i_wb_stall  in  1  slave stall
- i_wb_err  in  1  slave error
- o_bus_err  out  1  one-cycle pulse alongside o_mem_ready when terminated by err or timeout
- o_timeout  out  1  one-cycle pulse when terminated by timeout

Behaviour:
- Reset (async assert, sync release): state=IDLE. All outputs 0, including o_wb_addr, o_wb_data, o_mem_rdata and the timeout counter. Asserting reset mid-transaction drops cyc/stb immediately; no ready pulse is issued.
- All outputs are registered.
- IDLE: on an edge with i_mem_valid=1, latch the request and go to REQ:
  - o_wb_addr = i_mem_addr; o_wb_data = i_mem_wdata
  - o_wb_we = |i_mem_wstrb
  - o_wb_sel = we ? i_mem_wstrb : 4'hF
  - cyc=stb=1 from the next cycle
  - clear the timeout counter
- REQ: cyc=stb=1. Edge with i_wb_stall=0: request accepted; stb=0; go to WAIT. An ack or err seen on the accepting edge completes immediately (go to DONE).
- WAIT: cyc=1, stb=0. Edge with i_wb_ack=1 or i_wb_err=1 goes to DONE. If both are high, err wins.
- Entering DONE (registered, same edge):
  - cyc=0, stb=0, o_mem_ready=1 for exactly one cycle.
  - ack on a read: o_mem_rdata = i_wb_data.
  - ack on a write: o_mem_rdata = 0.
  - err: o_mem_rdata = ERR_RDATA, o_bus_err=1.
- DONE lasts one cycle, then IDLE. i_mem_valid is not sampled in DONE; the CPU drops valid on the ready edge, so no request is duplicated.
- Timeout: the counter (width clog2(TIMEOUT_CYCLES+1)) increments every cycle in REQ and WAIT. When it reaches TIMEOUT_CYCLES with no ack/err, go to DONE with ERR_RDATA, o_bus_err=1 and o_timeout=1. An ack arriving on the same edge as expiry wins as a normal completion.
- ack, err and stall are ignored while cyc=0. Stray acks in IDLE have no effect.
- o_wb_addr, o_wb_data, o_wb_sel and o_wb_we hold stable for the whole of cyc.
- Latency with a zero-wait, registered-ack slave (stall=0):
  - valid sampled at edge 0
  - cyc/stb high during cycle 1
  - ack high during cycle 2
  - o_mem_ready high during cycle 3
- Each additional stall or ack-wait cycle adds one cycle.
- A change of i_mem_valid, i_mem_addr or i_mem_wdata mid-transaction does not affect the bus cycle in progress.

Test Plan:
- Write to the LED slave: addr 0x8000_0000, wdata 0x0000_002A, wstrb 4'hF, registered-ack slave.
  -> cyc/stb for 1 cycle with we=1, sel=F, data=0x2A; ack next cycle; one mem_ready pulse 3 cycles after valid; bus_err=0.
- Read: wstrb 0, slave returns 0x0000_0015.
  -> we=0, sel=F; o_mem_rdata=0x15 during the single ready cycle.
- Byte write: wstrb 4'b0010, wdata 0x0000_AB00, stall held 3 cycles.
  -> stb held 4 cycles; sel=0010; addr/data stable throughout; ready after ack.
- Error: slave asserts err instead of ack on a read.
  -> ready pulse with rdata=0xDEAD_BEEF and bus_err=1; timeout=0; cyc drops the same edge.
- Timeout, TIMEOUT_CYCLES=16, slave never acks.
  -> cyc stays high 16 cycles, then drops; ready + bus_err + timeout pulse together; rdata=0xDEAD_BEEF. A late ack afterwards is ignored.
- Reset asserted during WAIT.
  -> cyc/stb/ready go 0 asynchronously. After release, a new read completes normally with no stale ready pulse.

Source files
------------

// File: rtl/wb_picorv32_master.sv
`default_nettype none
// ============================================================================
// Module : wb_picorv32_master
// Brief  : picorv32 native memory port to pipelined Wishbone single-cycle
//          master, with error and timeout termination.
// Rev    : 1.0  initial release
// ============================================================================
module wb_picorv32_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_mem_valid,
  input  logic        i_mem_instr,
  input  logic [31:0] i_mem_addr,
  input  logic [31:0] i_mem_wdata,
  input  logic [3:0]  i_mem_wstrb,
  output logic        o_mem_ready,
  output logic [31:0] o_mem_rdata,
  output logic [31:0] o_wb_addr,
  output logic [31:0] o_wb_data,
  output logic [3:0]  o_wb_sel,
  output logic        o_wb_we,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  input  logic        i_wb_ack,
  input  logic [31:0] i_wb_data,
  input  logic        i_wb_stall,
  input  logic        i_wb_err,
  output logic        o_bus_err,
  output logic        o_timeout
);

  localparam int unsigned c_CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST =
    (TIMEOUT_CYCLES > 0) ? c_CNT_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic c_TO_EN = (TIMEOUT_CYCLES > 0);

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_REQ  = 2'd1;
  localparam logic [1:0] c_ST_WAIT = 2'd2;
  localparam logic [1:0] c_ST_DONE = 2'd3;

  logic [1:0]         r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic [31:0]        r_wb_addr;
  logic [31:0]        r_wb_data;
  logic [31:0]        r_mem_rdata;
  logic [3:0]         r_wb_sel;
  logic               r_wb_we;
  logic               r_wb_cyc;
  logic               r_wb_stb;
  logic               r_mem_ready;
  logic               r_bus_err;
  logic               r_timeout;

  logic               w_live;
  logic               w_ack;
  logic               w_err;
  logic               w_expire;
  logic               w_abort;
  logic               w_finish;
  logic               w_req_we;
  logic [31:0]        w_done_rdata;
  logic               w_unused_instr;

  assign w_unused_instr = i_mem_instr;

  // Slave responses only count once the strobe has been accepted.
  assign w_live   = (r_state == c_ST_WAIT) || ((r_state == c_ST_REQ) && !i_wb_stall);
  assign w_err    = w_live && i_wb_err;
  assign w_ack    = w_live && i_wb_ack && !i_wb_err;
  assign w_expire = c_TO_EN && (r_cnt == c_CNT_LAST);
  assign w_abort  = w_expire && !w_ack && !w_err;
  assign w_finish = w_ack || w_err || w_expire;
  assign w_req_we = |i_mem_wstrb;

  assign w_done_rdata = w_ack ? (r_wb_we ? 32'h0 : i_wb_data) : ERR_RDATA;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= c_ST_IDLE;
      r_cnt       <= '0;
      r_wb_addr   <= 32'h0;
      r_wb_data   <= 32'h0;
      r_wb_sel    <= 4'h0;
      r_wb_we     <= 1'b0;
      r_wb_cyc    <= 1'b0;
      r_wb_stb    <= 1'b0;
      r_mem_ready <= 1'b0;
      r_mem_rdata <= 32'h0;
      r_bus_err   <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_mem_ready <= 1'b0;
      r_bus_err   <= 1'b0;
      r_timeout   <= 1'b0;
      case (r_state)
        c_ST_IDLE: begin
          if (i_mem_valid) begin
            r_wb_addr <= i_mem_addr;
            r_wb_data <= i_mem_wdata;
            r_wb_we   <= w_req_we;
            r_wb_sel  <= w_req_we ? i_mem_wstrb : 4'hF;
            r_wb_cyc  <= 1'b1;
            r_wb_stb  <= 1'b1;
            r_cnt     <= '0;
            r_state   <= c_ST_REQ;
          end
        end
        c_ST_REQ, c_ST_WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_finish) begin
            // A real response on the expiry edge beats the timeout.
            r_wb_cyc    <= 1'b0;
            r_wb_stb    <= 1'b0;
            r_mem_ready <= 1'b1;
            r_mem_rdata <= w_done_rdata;
            r_bus_err   <= w_err || w_abort;
            r_timeout   <= w_abort;
            r_state     <= c_ST_DONE;
          end else if ((r_state == c_ST_REQ) && !i_wb_stall) begin
            r_wb_stb <= 1'b0;
            r_state  <= c_ST_WAIT;
          end
        end
        c_ST_DONE: begin
          r_state <= c_ST_IDLE;
        end
        default: begin
          r_state <= c_ST_IDLE;
        end
      endcase
    end
  end

  assign o_mem_ready = r_mem_ready;
  assign o_mem_rdata = r_mem_rdata;
  assign o_wb_addr   = r_wb_addr;
  assign o_wb_data   = r_wb_data;
  assign o_wb_sel    = r_wb_sel;
  assign o_wb_we     = r_wb_we;
  assign o_wb_cyc    = r_wb_cyc;
  assign o_wb_stb    = r_wb_stb;
  assign o_bus_err   = r_bus_err;
  assign o_timeout   = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_wb_picorv32_master.sv
`default_nettype none
// ============================================================================
// Module : tb_wb_picorv32_master
// Brief  : directed bench; a timeline model predicts every bus cycle.
// Rev    : 1.0  initial release
// ============================================================================
module tb_wb_picorv32_master;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_valid = 1'b0;
  logic        mem_instr = 1'b0;
  logic [31:0] mem_addr = 32'h0;
  logic [31:0] mem_wdata = 32'h0;
  logic [3:0]  mem_wstrb = 4'h0;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [31:0] wb_addr;
  logic [31:0] wb_wdata;
  logic [3:0]  wb_sel;
  logic        wb_we;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_ack = 1'b0;
  logic [31:0] wb_rdata = 32'h0;
  logic        wb_stall = 1'b0;
  logic        wb_err = 1'b0;
  logic        bus_err;
  logic        timeout;

  wb_picorv32_master #(
    .TIMEOUT_CYCLES(TO),
    .ERR_RDATA     (32'hDEAD_BEEF)
  ) dut (
    .i_clk      (clk),
    .i_reset_n  (rst_n),
    .i_mem_valid(mem_valid),
    .i_mem_instr(mem_instr),
    .i_mem_addr (mem_addr),
    .i_mem_wdata(mem_wdata),
    .i_mem_wstrb(mem_wstrb),
    .o_mem_ready(mem_ready),
    .o_mem_rdata(mem_rdata),
    .o_wb_addr  (wb_addr),
    .o_wb_data  (wb_wdata),
    .o_wb_sel   (wb_sel),
    .o_wb_we    (wb_we),
    .o_wb_cyc   (wb_cyc),
    .o_wb_stb   (wb_stb),
    .i_wb_ack   (wb_ack),
    .i_wb_data  (wb_rdata),
    .i_wb_stall (wb_stall),
    .i_wb_err   (wb_err),
    .o_bus_err  (bus_err),
    .o_timeout  (timeout)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected outputs for the current cycle, written by the stimulus process.
  logic        chk_en = 1'b0;
  int          cur_k = 0;
  logic        exp_cyc = 1'b0, exp_stb = 1'b0, exp_we = 1'b0;
  logic        exp_ready = 1'b0, exp_berr = 1'b0, exp_to = 1'b0;
  logic [3:0]  exp_sel = 4'h0;
  logic [31:0] exp_addr = 32'h0, exp_data = 32'h0, exp_rdata = 32'h0;

  int          obs_cnt = 0;
  int          obs_k = -1;
  logic [31:0] obs_rdata = 32'h0;
  logic        obs_berr = 1'b0, obs_to = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc",     32'(wb_cyc),    32'(exp_cyc));
      chk("stb",     32'(wb_stb),    32'(exp_stb));
      chk("ready",   32'(mem_ready), 32'(exp_ready));
      chk("bus_err", 32'(bus_err),   32'(exp_berr));
      chk("timeout", 32'(timeout),   32'(exp_to));
      if (exp_cyc) begin
        chk("wb_addr", wb_addr,       exp_addr);
        chk("wb_data", wb_wdata,      exp_data);
        chk("wb_sel",  32'(wb_sel),   32'(exp_sel));
        chk("wb_we",   32'(wb_we),    32'(exp_we));
      end
      if (exp_ready) chk("rdata", mem_rdata, exp_rdata);
      if (mem_ready) begin
        obs_cnt++;
        obs_k     = cur_k;
        obs_rdata = mem_rdata;
        obs_berr  = bus_err;
        obs_to    = timeout;
      end
    end
  end

  // resp: bit0 = slave acks, bit1 = slave errs, both at cycle s+1+d.
  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          s;
    int          d;
    int          resp;
    logic [31:0] sdata;
    int          abort_k;
    int          h_ready;
    logic [31:0] h_rdata;
    logic        h_berr;
    logic        h_to;
  } vec_t;

  task automatic run_txn(input vec_t v);
    int          rc, tend, r;
    logic        ok, eterm, we;
    logic [3:0]  sel;
    logic [31:0] erd;
    bit          aborted;
    // Timeline: valid sampled at edge 0, bus cycles numbered from 1.
    rc    = v.s + 1 + v.d;
    ok    = (v.resp != 0) && (rc <= TO);
    tend  = ok ? rc : TO;
    r     = tend + 1;
    eterm = !ok || ((v.resp & 2) != 0);
    we    = (v.wstrb != 4'h0);
    sel   = we ? v.wstrb : 4'hF;
    erd   = eterm ? 32'hDEAD_BEEF : (we ? 32'h0 : v.sdata);
    obs_cnt = 0; obs_k = -1; obs_rdata = 32'h0; obs_berr = 1'b0; obs_to = 1'b0;
    aborted = 1'b0;
    for (int k = 0; k <= r + 1 && !aborted; k++) begin
      cur_k     = k;
      mem_valid = (k <= r);
      mem_instr = 1'($urandom);
      if (k == 0) begin
        mem_addr  = v.addr;
        mem_wdata = v.wdata;
        mem_wstrb = v.wstrb;
      end else begin
        mem_addr  = $urandom;
        mem_wdata = $urandom;
        mem_wstrb = 4'($urandom);
      end
      wb_stall  = (k >= 1) && (k <= v.s);
      wb_ack    = ((k == rc) && ((v.resp & 1) != 0)) || (k == r + 1);
      wb_err    = (k == rc) && ((v.resp & 2) != 0);
      wb_rdata  = (k == rc) ? v.sdata : $urandom;
      exp_cyc   = (k >= 1) && (k <= tend);
      exp_stb   = (k >= 1) && (k <= v.s + 1) && (k <= tend);
      exp_ready = (k == r);
      exp_berr  = exp_ready && eterm;
      exp_to    = exp_ready && !ok;
      exp_addr  = v.addr;
      exp_data  = v.wdata;
      exp_sel   = sel;
      exp_we    = we;
      exp_rdata = erd;
      if (k == v.abort_k) begin
        #2 rst_n = 1'b0;
        #1;
        chk("abort_cyc",   32'(wb_cyc),    32'h0);
        chk("abort_stb",   32'(wb_stb),    32'h0);
        chk("abort_ready", 32'(mem_ready), 32'h0);
        mem_valid = 1'b0; wb_ack = 1'b0; wb_err = 1'b0; wb_stall = 1'b0;
        exp_cyc = 1'b0; exp_stb = 1'b0; exp_ready = 1'b0;
        exp_berr = 1'b0; exp_to = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        aborted = 1'b1;
      end
      @(negedge clk);
      @(posedge clk);
      #1;
    end
    if (aborted) begin
      chk("abort_no_ready", 32'(obs_cnt), 32'h0);
    end else begin
      chk("ready_count", 32'(obs_cnt),  32'h1);
      chk("ready_cycle", 32'(obs_k),    32'(v.h_ready));
      chk("hand_rdata",  obs_rdata,     v.h_rdata);
      chk("hand_berr",   32'(obs_berr), 32'(v.h_berr));
      chk("hand_to",     32'(obs_to),   32'(v.h_to));
    end
  endtask

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{32'h8000_0000, 32'h0000_002A, 4'hF, 0, 1,  1, 32'h1111_1111, -1, 3,  32'h0000_0000, 1'b0, 1'b0};
    vecs[1]  = '{32'h8000_0004, 32'hFFFF_FFFF, 4'h0, 0, 1,  1, 32'h0000_0015, -1, 3,  32'h0000_0015, 1'b0, 1'b0};
    vecs[2]  = '{32'h8000_0008, 32'h0000_AB00, 4'h2, 3, 1,  1, 32'h5555_5555, -1, 6,  32'h0000_0000, 1'b0, 1'b0};
    vecs[3]  = '{32'h8000_000C, 32'h0000_0000, 4'h0, 0, 1,  2, 32'h0000_1234, -1, 3,  32'hDEAD_BEEF, 1'b1, 1'b0};
    vecs[4]  = '{32'h8000_0010, 32'h0000_0000, 4'h0, 0, 16, 1, 32'h9999_9999, -1, 17, 32'hDEAD_BEEF, 1'b1, 1'b1};
    vecs[5]  = '{32'h8000_0014, 32'h0000_0000, 4'h0, 0, 15, 1, 32'h1234_5678, -1, 17, 32'h1234_5678, 1'b0, 1'b0};
    vecs[6]  = '{32'h8000_0018, 32'h0000_0000, 4'h0, 2, 0,  1, 32'hCAFE_0001, -1, 4,  32'hCAFE_0001, 1'b0, 1'b0};
    vecs[7]  = '{32'h8000_001C, 32'h0000_0000, 4'h0, 0, 2,  3, 32'h0000_00AA, -1, 4,  32'hDEAD_BEEF, 1'b1, 1'b0};
    vecs[8]  = '{32'h8000_0020, 32'h0BAD_F00D, 4'hC, 5, 0,  0, 32'h0000_0000, -1, 17, 32'hDEAD_BEEF, 1'b1, 1'b1};
    vecs[9]  = '{32'h8000_0024, 32'h0000_0000, 4'h0, 0, 0,  0, 32'h0000_0000, 3,  0,  32'h0000_0000, 1'b0, 1'b0};
    vecs[10] = '{32'h8000_0028, 32'h0000_0000, 4'h0, 1, 1,  1, 32'h0000_0077, -1, 4,  32'h0000_0077, 1'b0, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_cyc",   32'(wb_cyc),    32'h0);
    chk("rst_stb",   32'(wb_stb),    32'h0);
    chk("rst_ready", 32'(mem_ready), 32'h0);
    chk("rst_addr",  wb_addr,        32'h0);
    chk("rst_wdata", wb_wdata,       32'h0);
    chk("rst_rdata", mem_rdata,      32'h0);
    chk("rst_sel",   32'(wb_sel),    32'h0);
    chk("rst_we",    32'(wb_we),     32'h0);
    chk("rst_berr",  32'(bus_err),   32'h0);
    chk("rst_to",    32'(timeout),   32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    foreach (vecs[i]) run_txn(vecs[i]);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
